// File: rtl/sha256_pad_pkg.sv
// Shared types and constants for the SHA-256 padding stage.
// Optional build macro: SHA256_PAD_OVERFLOW_CHK_EN (see sha256_pad.sv).
package sha256_pad_pkg;

    localparam int         WORD_W             = 32;
    localparam logic [7:0] SHA256_PAD_BYTE    = 8'h80;
    localparam int         SHA256_BLOCK_WORDS = 16;
    localparam logic [3:0] SHA256_LEN_OFFSET  = 4'd14;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_PAD80W = 3'd2,
        ST_ZERO   = 3'd3,
        ST_LEN_HI = 3'd4,
        ST_LEN_LO = 3'd5,
        ST_HDR    = 3'd6,
        ST_DONE   = 3'd7
    } pad_state_e;

    // Blocks needed for a message of the given bit length: 0x80 plus 8 length bytes must fit.
    function automatic logic [63:0] blocks_for_bits(input logic [63:0] bits);
        return (((bits >> 3) + 64'd8) >> 6) + 64'd1;
    endfunction

endpackage

// File: rtl/sha256_pad_byte_packer.sv
// Packs bytes MSB-first into 32-bit words and builds the 0x80-terminated partial word.
// Word output is combinational with the pushed byte; the holding register is internal.
module sha256_pad_byte_packer
    import sha256_pad_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic [7:0]        byte_in,
    output logic              word_valid,
    output logic [WORD_W-1:0] word,
    output logic [WORD_W-1:0] pad_word
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] acc_q, acc_d;

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (clear) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (push) begin
            cnt_d = cnt_q + 2'd1;
            acc_d = {acc_q[15:0], byte_in};
        end
    end

    assign word_valid = push && (cnt_q == 2'd3);
    assign word       = {acc_q, byte_in};

    // The newest byte sits in acc_q[7:0]; the pad byte goes in the first free lane below.
    always_comb begin
        case (cnt_q)
            2'd0:    pad_word = {SHA256_PAD_BYTE, 24'h0};
            2'd1:    pad_word = {acc_q[7:0], SHA256_PAD_BYTE, 16'h0};
            2'd2:    pad_word = {acc_q[15:0], SHA256_PAD_BYTE, 8'h0};
            default: pad_word = {acc_q[23:0], SHA256_PAD_BYTE};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/sha256_pad.sv
// Byte stream to padded SHA-256 word buffer (header at address 0, message word k at k+1).
// Build macro SHA256_PAD_OVERFLOW_CHK_EN adds a sticky overflow output and drains oversize messages.
module sha256_pad
    import sha256_pad_pkg::*;
#(
    parameter int MAX_BLOCKS = 2,
    parameter int ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic              in_empty,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W-5:0] num_blocks,
    output logic [63:0]       msg_bits,
    output logic              done,
    output logic [2:0]        dbg_state
`ifdef SHA256_PAD_OVERFLOW_CHK_EN
    ,
    output logic              overflow
`endif
);

    localparam int                NB_W      = ADDR_W - 4;
    localparam logic [ADDR_W-1:0] CAP_WORDS = ADDR_W'(SHA256_BLOCK_WORDS * MAX_BLOCKS);

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready; in_ready is
    // registered, is high only in IDLE/DATA, and in_valid is ignored while it is low.

    pad_state_e        state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic [NB_W-1:0]   num_blocks_q, num_blocks_d;
    logic [63:0]       bit_cnt_q, bit_cnt_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic              drop_q, drop_d;
`ifdef SHA256_PAD_OVERFLOW_CHK_EN
    logic              ov_q, ov_d;
`endif

    logic              accept;
    logic              pk_push, pk_clear, pk_word_valid;
    logic [WORD_W-1:0] pk_word, pk_pad_word;
    logic [ADDR_W-1:0] k_inc;
    logic              wr_req;
    logic [31:0]       wr_word;
    logic              ov_now;

    assign accept  = in_valid && in_ready_q;
    assign pk_push = accept && !(state_q == ST_IDLE && in_last && in_empty);
    assign k_inc   = k_q + ADDR_W'(1);

    sha256_pad_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pk_clear),
        .push       (pk_push),
        .byte_in    (in_data),
        .word_valid (pk_word_valid),
        .word       (pk_word),
        .pad_word   (pk_pad_word)
    );

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        drop_d       = drop_q;
        bit_cnt_d    = bit_cnt_q;
        num_blocks_d = num_blocks_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        done_d       = 1'b0;
        pk_clear     = 1'b0;
        wr_req       = 1'b0;
        wr_word      = '0;
        ov_now       = 1'b0;
`ifdef SHA256_PAD_OVERFLOW_CHK_EN
        ov_d         = ov_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    k_d    = '0;
                    drop_d = 1'b0;
`ifdef SHA256_PAD_OVERFLOW_CHK_EN
                    ov_d   = 1'b0;
`endif
                    if (in_last && in_empty) begin
                        bit_cnt_d = '0;
                        pk_clear  = 1'b1;
                    end else begin
                        bit_cnt_d = 64'd8;
                    end
                    if (in_last) begin
                        num_blocks_d = NB_W'(blocks_for_bits(bit_cnt_d));
                        state_d      = ST_PAD80W;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    bit_cnt_d = bit_cnt_q + 64'd8;
`ifdef SHA256_PAD_OVERFLOW_CHK_EN
                    if (blocks_for_bits(bit_cnt_d) > 64'(MAX_BLOCKS)) begin
                        ov_d = 1'b1;
                    end
                    ov_now = ov_d;
`endif
                    if (pk_word_valid && !ov_now) begin
                        wr_req  = 1'b1;
                        wr_word = pk_word;
                    end
                    if (in_last) begin
                        if (ov_now) begin
                            pk_clear = 1'b1;
                            state_d  = ST_IDLE;
                        end else begin
                            num_blocks_d = NB_W'(blocks_for_bits(bit_cnt_d));
                            state_d      = ST_PAD80W;
                        end
                    end
                end
            end
            ST_PAD80W: begin
                wr_req   = 1'b1;
                wr_word  = pk_pad_word;
                pk_clear = 1'b1;
                state_d  = (k_inc[3:0] == SHA256_LEN_OFFSET) ? ST_LEN_HI : ST_ZERO;
            end
            ST_ZERO: begin
                wr_req  = 1'b1;
                state_d = (k_inc[3:0] == SHA256_LEN_OFFSET) ? ST_LEN_HI : ST_ZERO;
            end
            ST_LEN_HI: begin
                wr_req  = 1'b1;
                wr_word = bit_cnt_q[63:32];
                state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                wr_req  = 1'b1;
                wr_word = bit_cnt_q[31:0];
                state_d = ST_HDR;
            end
            ST_HDR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = '0;
                wr_data_d = 32'(num_blocks_q);
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Message words past the buffer are still counted so offsets stay right, but never written.
        if (wr_req) begin
            wr_en_d   = !drop_q;
            wr_addr_d = k_inc;
            wr_data_d = wr_word;
            k_d       = k_inc;
            if (k_inc == CAP_WORDS) begin
                drop_d = 1'b1;
            end
        end

        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_DATA);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            in_ready_q   <= 1'b1;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            num_blocks_q <= '0;
            bit_cnt_q    <= '0;
            done_q       <= 1'b0;
            k_q          <= '0;
            drop_q       <= 1'b0;
`ifdef SHA256_PAD_OVERFLOW_CHK_EN
            ov_q         <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            num_blocks_q <= num_blocks_d;
            bit_cnt_q    <= bit_cnt_d;
            done_q       <= done_d;
            k_q          <= k_d;
            drop_q       <= drop_d;
`ifdef SHA256_PAD_OVERFLOW_CHK_EN
            ov_q         <= ov_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign num_blocks = num_blocks_q;
    assign msg_bits   = bit_cnt_q;
    assign done       = done_q;
    assign dbg_state  = state_q;
`ifdef SHA256_PAD_OVERFLOW_CHK_EN
    assign overflow   = ov_q;
`endif

endmodule

// File: tb/tb_sha256_pad.sv
// Bench for sha256_pad: fixed vectors, hand sequences and random messages
// checked against a byte-level FIPS 180-4 padding model.
module tb_sha256_pad;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        in_data;
    logic              in_valid, in_last, in_empty;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [1:0]        num_blocks;
    logic [63:0]       msg_bits;
    logic              done;
    logic [2:0]        dbg_state;
`ifdef SHA256_PAD_OVERFLOW_CHK_EN
    logic              overflow;
`endif

    sha256_pad #(.MAX_BLOCKS(2), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_empty   (in_empty),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .num_blocks (num_blocks),
        .msg_bits   (msg_bits),
        .done       (done),
        .dbg_state  (dbg_state)
`ifdef SHA256_PAD_OVERFLOW_CHK_EN
        ,
        .overflow   (overflow)
`endif
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] cap_mem [0:63];
    int          wr_count = 0;
    int          done_cnt = 0;
    logic [1:0]  done_nb;
    logic [63:0] done_bits;

    logic [7:0]  msg_q[$];
    logic [31:0] exp_q[$];
    int          exp_nb;
    logic [63:0] exp_bits;

    typedef struct {
        int          len;
        logic [7:0]  fill;
        int          nb;
        int          a1;
        logic [31:0] w1;
        int          a2;
        logic [31:0] w2;
    } vec_t;

    vec_t vecs [6];

    // Monitor: the buffer as the DUT writes it, plus the done pulse snapshot.
    always @(negedge clk) begin
        if (wr_en) begin
            cap_mem[wr_addr] = wr_data;
            wr_count++;
        end
        if (done) begin
            done_cnt++;
            done_nb   = num_blocks;
            done_bits = msg_bits;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: pad the byte list with 0x80, zeros to 56 mod 64, then the 64-bit bit length.
    task automatic build_model();
        logic [7:0]  pq[$];
        logic [63:0] bl;
        pq = msg_q;
        bl = 64'(msg_q.size()) * 64'd8;
        pq.push_back(8'h80);
        while (pq.size() % 64 != 56) pq.push_back(8'h00);
        for (int i = 7; i >= 0; i--) pq.push_back(bl[8*i +: 8]);
        exp_nb   = pq.size() / 64;
        exp_bits = bl;
        exp_q    = {};
        for (int i = 0; i < pq.size(); i += 4)
            exp_q.push_back({pq[i], pq[i+1], pq[i+2], pq[i+3]});
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic put_byte(input logic [7:0] b, input logic last, input logic empty);
        int t;
        in_data  = b;
        in_last  = last;
        in_empty = empty;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("in_ready_timeout", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
    endtask

    task automatic send_msg(input bit gaps);
        if (msg_q.size() == 0) begin
            put_byte(8'($urandom_range(0, 255)), 1'b1, 1'b1);
        end else begin
            for (int i = 0; i < msg_q.size(); i++) begin
                put_byte(msg_q[i], i == msg_q.size() - 1, 1'b0);
                if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
    endtask

    task automatic run_and_check(input string tag, input bit gaps);
        int t, start_done, bad;
        for (int a = 0; a < 64; a++) cap_mem[a] = 32'hDEADBEEF;
        wr_count   = 0;
        start_done = done_cnt;
        build_model();
        send_msg(gaps);
        t = 0;
        while (done_cnt == start_done && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        check({tag, " done_pulses"}, 64'(done_cnt - start_done), 64'd1);
        check({tag, " num_blocks"}, 64'(done_nb), 64'(exp_nb));
        check({tag, " msg_bits"}, done_bits, exp_bits);
        check({tag, " msg_bits_hold"}, msg_bits, exp_bits);
        check({tag, " header"}, 64'(cap_mem[0]), 64'(exp_nb));
        check({tag, " write_count"}, 64'(wr_count), 64'(16 * exp_nb + 1));
        bad = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (cap_mem[i+1] !== exp_q[i] && bad < 0) bad = i;
        n_tests++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s body: addr %0d got %h expected %h", tag, bad + 1, cap_mem[bad+1], exp_q[bad]);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int sd;
        vecs[0] = '{0,  8'h00, 1, 1,  32'h80000000, 16, 32'h00000000};
        vecs[1] = '{55, 8'h61, 1, 14, 32'h61616180, 16, 32'h000001B8};
        vecs[2] = '{56, 8'h61, 2, 15, 32'h80000000, 32, 32'h000001C0};
        vecs[3] = '{4,  8'hA5, 1, 1,  32'hA5A5A5A5, 2,  32'h80000000};
        vecs[4] = '{63, 8'h61, 2, 16, 32'h61616180, 32, 32'h000001F8};
        vecs[5] = '{64, 8'h61, 2, 17, 32'h80000000, 32, 32'h00000200};

        reset    = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
        repeat (3) @(negedge clk);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset wr_en", 64'(wr_en), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset msg_bits", msg_bits, 64'd0);
        check("reset num_blocks", 64'(num_blocks), 64'd0);
        check("reset wr_data", 64'(wr_data), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        msg_q = {8'h61, 8'h62, 8'h63};
        run_and_check("abc", 1'b0);
        check("abc addr1", 64'(cap_mem[1]), 64'h61626380);
        check("abc addr14", 64'(cap_mem[14]), 64'h0);
        check("abc addr15", 64'(cap_mem[15]), 64'h0);
        check("abc addr16", 64'(cap_mem[16]), 64'h18);

        for (int v = 0; v < 6; v++) begin
            msg_q = {};
            repeat (vecs[v].len) msg_q.push_back(vecs[v].fill);
            run_and_check($sformatf("vec%0d", v), 1'b0);
            check($sformatf("vec%0d nb_table", v), 64'(done_nb), 64'(vecs[v].nb));
            check($sformatf("vec%0d addr%0d", v, vecs[v].a1), 64'(cap_mem[vecs[v].a1]), 64'(vecs[v].w1));
            check($sformatf("vec%0d addr%0d", v, vecs[v].a2), 64'(cap_mem[vecs[v].a2]), 64'(vecs[v].w2));
        end

        // Reset after 20 bytes aborts the message cleanly.
        for (int i = 0; i < 20; i++) put_byte(8'h61, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset in_ready", 64'(in_ready), 64'd1);
        check("midreset wr_en", 64'(wr_en), 64'd0);
        wr_count = 0;
        sd = done_cnt;
        repeat (40) @(negedge clk);
        check("midreset writes", 64'(wr_count), 64'd0);
        check("midreset done", 64'(done_cnt - sd), 64'd0);
        msg_q = {8'h61, 8'h62, 8'h63};
        run_and_check("abc_after_reset", 1'b1);
        check("abc_after_reset addr1", 64'(cap_mem[1]), 64'h61626380);

`ifdef SHA256_PAD_OVERFLOW_CHK_EN
        msg_q = {};
        repeat (120) msg_q.push_back(8'h61);
        sd = done_cnt;
        send_msg(1'b0);
        check("ovf flag", 64'(overflow), 64'd1);
        repeat (60) @(negedge clk);
        check("ovf no_done", 64'(done_cnt - sd), 64'd0);
        msg_q = {8'h61, 8'h62, 8'h63};
        run_and_check("abc_after_ovf", 1'b0);
        check("ovf cleared", 64'(overflow), 64'd0);
`endif

        for (int r = 0; r < 25; r++) begin
            int len;
            len   = $urandom_range(0, 119);
            msg_q = {};
            repeat (len) msg_q.push_back(8'($urandom_range(0, 255)));
            run_and_check($sformatf("rand%0d_len%0d", r, len), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
